// File: rtl/pl1_emu_pkg.sv
// Shared types and constants for the PL1 typewriter/coupler emulator.
//   key_e        - PL1 function-key select, value = bit index on key_lines
//   key_state_e  - key sequencer states
//   typed_s      - one captured character (LEV code + AN mode)
package pl1_emu_pkg;

    localparam int unsigned NUM_KEYS   = 13;
    localparam int unsigned KEY_CODE_W = 4;
    localparam int unsigned LEV_W      = 5;

    typedef enum logic [3:0] {
        KEY_CIR_S = 4'd0,
        KEY_A     = 4'd1,
        KEY_B     = 4'd2,
        KEY_C     = 4'd3,
        KEY_E     = 4'd4,
        KEY_F     = 4'd5,
        KEY_I     = 4'd6,
        KEY_M     = 4'd7,
        KEY_P     = 4'd8,
        KEY_Q     = 4'd9,
        KEY_R     = 4'd10,
        KEY_T     = 4'd11,
        KEY_FB    = 4'd12
    } key_e;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_HOLD,
        KS_GAP
    } key_state_e;

    typedef struct packed {
        logic             an;
        logic [LEV_W-1:0] code;
    } typed_s;

    // Codes above the last defined key have no PL1 line.
    function automatic logic key_defined(input logic [KEY_CODE_W-1:0] code);
        return code <= KEY_CODE_W'(KEY_FB);
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [KEY_CODE_W-1:0] code);
        return NUM_KEYS'(1) << code;
    endfunction

endpackage

// File: rtl/pl1_typewriter_emu_if.sv
// PL1 emulator bus: host key requests, PL1 key lines, G-15 type strobes,
// captured-character handshake and LEV OUT echo.
//   master - host / G-15 side (drives requests and strobes)
//   slave  - emulator side
interface pl1_typewriter_emu_if
    import pl1_emu_pkg::*;
;
    logic                  key_valid;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_ready;
    logic [NUM_KEYS-1:0]   key_lines;
    logic                  bad_key;

    logic                  pl1_type;
    logic                  pl1_exc;
    logic                  pl1_an;
    logic [LEV_W-1:0]      pl1_lev_in;

    logic                  typed_valid;
    logic [LEV_W-1:0]      typed_code;
    logic                  typed_an;
    logic                  typed_ready;
    logic                  overrun;
    logic [LEV_W-1:0]      lev_out;

    modport master (
        output key_valid, key_code, pl1_type, pl1_exc, pl1_an, pl1_lev_in, typed_ready,
        input  key_ready, key_lines, bad_key, typed_valid, typed_code, typed_an,
               overrun, lev_out
    );

    modport slave (
        input  key_valid, key_code, pl1_type, pl1_exc, pl1_an, pl1_lev_in, typed_ready,
        output key_ready, key_lines, bad_key, typed_valid, typed_code, typed_an,
               overrun, lev_out
    );

endinterface

// File: rtl/pl1_hold_timer.sv
// Loadable down-counter. load_val = N-1 gives done_c after N cycles;
// the count parks at zero (no wrap).
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (takes priority over counting)
//   load_val  - start value
//   done_c    - combinational: count is zero
module pl1_hold_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/pl1_typewriter_emu.sv
// IBM I/O writer + ANC-2 coupler emulator on PL1.
//   CLOCK, rst - system clock, synchronous active-high reset
//   bus        - slave side of pl1_typewriter_emu_if:
//                key_valid/key_code/key_ready  host key request handshake
//                key_lines, bad_key            timed one-hot key pulses, illegal-code pulse
//                pl1_type/exc/an/lev_in        G-15 type strobes and LEV IN code
//                typed_valid/code/an/ready     captured character handshake
//                overrun                       sticky capture-while-full flag
//                lev_out                       LEV OUT echo to the G-15
module pl1_typewriter_emu
    import pl1_emu_pkg::*;
#(
    parameter int unsigned KEY_HOLD_CYCLES = 2_000_000,
    parameter int unsigned KEY_GAP_CYCLES  = 400_000,
    parameter int unsigned ECHO_CYCLES     = 400_000
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    pl1_typewriter_emu_if.slave  bus
);

    localparam int unsigned KEY_MAX = (KEY_HOLD_CYCLES > KEY_GAP_CYCLES) ?
                                      KEY_HOLD_CYCLES : KEY_GAP_CYCLES;
    localparam int unsigned KEY_W   = $clog2(KEY_MAX + 1);
    localparam int unsigned ECHO_W  = $clog2(ECHO_CYCLES + 1);

    if (KEY_HOLD_CYCLES < 1 || KEY_GAP_CYCLES < 1 || ECHO_CYCLES < 1) begin : g_param_check
        $error("pl1_typewriter_emu: cycle parameters must be at least 1");
    end

    key_state_e          state_q;
    logic                key_ready_q;
    logic [NUM_KEYS-1:0] key_lines_q;
    logic                bad_key_q;

    logic                exc_q;
    logic                typed_valid_q;
    typed_s              typed_q;
    logic                overrun_q;
    logic [LEV_W-1:0]    lev_out_q;

    logic                key_load_c;
    logic [KEY_W-1:0]    key_load_val_c;
    logic                key_done_c;
    logic                echo_done_c;
    logic                key_accept_c;
    logic                key_legal_c;
    logic                capture_c;
    logic                drain_c;

    assign key_accept_c = (state_q == KS_IDLE) && bus.key_valid;
    assign key_legal_c  = key_defined(bus.key_code);

    // G-15 strobes are already in CLOCK domain; only a rising-edge detect is needed.
    assign capture_c    = bus.pl1_exc && !exc_q && bus.pl1_type;
    assign drain_c      = typed_valid_q && bus.typed_ready;

    // Timer reload: hold length on acceptance, gap length when the hold expires.
    always_comb begin
        key_load_c     = 1'b0;
        key_load_val_c = '0;
        case (state_q)
            KS_IDLE: begin
                if (key_accept_c && key_legal_c) begin
                    key_load_c     = 1'b1;
                    key_load_val_c = KEY_W'(KEY_HOLD_CYCLES - 1);
                end
            end
            KS_HOLD: begin
                if (key_done_c) begin
                    key_load_c     = 1'b1;
                    key_load_val_c = KEY_W'(KEY_GAP_CYCLES - 1);
                end
            end
            default: ;
        endcase
    end

    pl1_hold_timer #(.W(KEY_W)) u_key_timer (
        .clk      (CLOCK),
        .rst      (rst),
        .load     (key_load_c),
        .load_val (key_load_val_c),
        .done_c   (key_done_c)
    );

    pl1_hold_timer #(.W(ECHO_W)) u_echo_timer (
        .clk      (CLOCK),
        .rst      (rst),
        .load     (capture_c),
        .load_val (ECHO_W'(ECHO_CYCLES - 1)),
        .done_c   (echo_done_c)
    );

    // Key sequencer: IDLE -> HOLD -> GAP -> IDLE, all outputs registered.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q     <= KS_IDLE;
            key_ready_q <= 1'b1;
            key_lines_q <= '0;
            bad_key_q   <= 1'b0;
        end else begin
            bad_key_q <= 1'b0;
            case (state_q)
                KS_IDLE: begin
                    if (key_accept_c) begin
                        if (key_legal_c) begin
                            state_q     <= KS_HOLD;
                            key_ready_q <= 1'b0;
                            key_lines_q <= key_onehot(bus.key_code);
                        end else begin
                            bad_key_q <= 1'b1;
                        end
                    end
                end
                KS_HOLD: begin
                    if (key_done_c) begin
                        state_q     <= KS_GAP;
                        key_lines_q <= '0;
                    end
                end
                KS_GAP: begin
                    if (key_done_c) begin
                        state_q     <= KS_IDLE;
                        key_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= KS_IDLE;
                    key_ready_q <= 1'b1;
                    key_lines_q <= '0;
                end
            endcase
        end
    end

    // Capture path: one-entry buffer, sticky overrun, LEV OUT echo.
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            exc_q         <= 1'b0;
            typed_valid_q <= 1'b0;
            typed_q       <= '0;
            overrun_q     <= 1'b0;
            lev_out_q     <= '0;
        end else begin
            exc_q <= bus.pl1_exc;

            if (capture_c) begin
                if (!typed_valid_q || drain_c) begin
                    typed_valid_q <= 1'b1;
                    typed_q       <= '{an: bus.pl1_an, code: bus.pl1_lev_in};
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (drain_c) begin
                typed_valid_q <= 1'b0;
            end

            // Echo restarts on every capture, dropped or not.
            if (capture_c) begin
                lev_out_q <= bus.pl1_lev_in;
            end else if (echo_done_c) begin
                lev_out_q <= '0;
            end
        end
    end

    assign bus.key_ready   = key_ready_q;
    assign bus.key_lines   = key_lines_q;
    assign bus.bad_key     = bad_key_q;
    assign bus.typed_valid = typed_valid_q;
    assign bus.typed_code  = typed_q.code;
    assign bus.typed_an    = typed_q.an;
    assign bus.overrun     = overrun_q;
    assign bus.lev_out     = lev_out_q;

endmodule

// File: tb/tb_pl1_typewriter_emu.sv
// Self-checking bench for pl1_typewriter_emu (HOLD=8, GAP=4, ECHO=5).
module tb_pl1_typewriter_emu;

    logic CLOCK = 1'b0;
    logic rst   = 1'b1;

    always #5 CLOCK = ~CLOCK;

    pl1_typewriter_emu_if bus ();

    pl1_typewriter_emu #(
        .KEY_HOLD_CYCLES (8),
        .KEY_GAP_CYCLES  (4),
        .ECHO_CYCLES     (5)
    ) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       an;
        logic [4:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;
    exp_t want;
    logic mdl_full    = 1'b0;
    logic mdl_overrun = 1'b0;
    int   checks      = 0;
    int   passes      = 0;

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic idle_inputs();
        bus.key_valid   = 1'b0;
        bus.key_code    = 4'd0;
        bus.pl1_type    = 1'b0;
        bus.pl1_exc     = 1'b0;
        bus.pl1_an      = 1'b0;
        bus.pl1_lev_in  = 5'd0;
        bus.typed_ready = 1'b0;
    endtask

    // Raise EXC with the given strobes; the buffer model decides accept vs overrun.
    task automatic capture_pulse(input logic [4:0] code, input logic an,
                                 input logic typ, input logic draining);
        bus.pl1_type   = typ;
        bus.pl1_an     = an;
        bus.pl1_lev_in = code;
        bus.pl1_exc    = 1'b1;
        if (typ) begin
            if (!mdl_full || draining) begin
                exp_q.push_back('{an: an, code: code});
                mdl_full = 1'b1;
            end else begin
                mdl_overrun = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready got=%b want=1", bus.key_ready); else passes++;
        checks++; if (bus.key_lines !== 13'h0) $display("FAIL reset_key_lines got=%h want=0", bus.key_lines); else passes++;
        checks++; if (bus.bad_key !== 1'b0) $display("FAIL reset_bad_key got=%b want=0", bus.bad_key); else passes++;
        checks++; if (bus.typed_valid !== 1'b0) $display("FAIL reset_typed_valid got=%b want=0", bus.typed_valid); else passes++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got=%b want=0", bus.overrun); else passes++;
        checks++; if (bus.lev_out !== 5'h0) $display("FAIL reset_lev_out got=%h want=0", bus.lev_out); else passes++;
        checks++; if ({bus.typed_an, bus.typed_code} !== 6'h0) $display("FAIL reset_typed_data got=%h want=0", {bus.typed_an, bus.typed_code}); else passes++;
        tick();
    endtask

    task automatic test_key_a();
        logic [12:0] exp_lines;
        logic        exp_ready;
        bus.key_code  = 4'd1;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            exp_lines = (k < 8) ? 13'h0002 : 13'h0000;
            exp_ready = (k >= 12);
            checks++; if (bus.key_lines !== exp_lines) $display("FAIL key_a_lines cyc=%0d got=%h want=%h", k, bus.key_lines, exp_lines); else passes++;
            checks++; if (bus.key_ready !== exp_ready) $display("FAIL key_a_ready cyc=%0d got=%b want=%b", k, bus.key_ready, exp_ready); else passes++;
            tick();
        end
    endtask

    task automatic test_bad_key();
        bus.key_code  = 4'd14;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++; if (bus.bad_key !== 1'b1) $display("FAIL bad_key_pulse got=%b want=1", bus.bad_key); else passes++;
        checks++; if (bus.key_lines !== 13'h0) $display("FAIL bad_key_lines got=%h want=0", bus.key_lines); else passes++;
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL bad_key_ready got=%b want=1", bus.key_ready); else passes++;
        tick();
        checks++; if (bus.bad_key !== 1'b0) $display("FAIL bad_key_width got=%b want=0", bus.bad_key); else passes++;
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL bad_key_ready2 got=%b want=1", bus.key_ready); else passes++;
    endtask

    // Host holds key_valid through HOLD and GAP; the second press starts right after GAP.
    task automatic test_back_to_back();
        logic [12:0] exp_lines;
        logic        exp_ready;
        bit          seen;
        bus.key_code  = 4'd12;
        bus.key_valid = 1'b1;
        tick();
        for (int k = 0; k <= 20; k++) begin
            exp_lines = (k < 8 || k >= 13) ? 13'h1000 : 13'h0000;
            exp_ready = (k == 12);
            checks++; if (bus.key_lines !== exp_lines) $display("FAIL b2b_lines cyc=%0d got=%h want=%h", k, bus.key_lines, exp_lines); else passes++;
            checks++; if (bus.key_ready !== exp_ready) $display("FAIL b2b_ready cyc=%0d got=%b want=%b", k, bus.key_ready, exp_ready); else passes++;
            if (k == 13) bus.key_valid = 1'b0;
            tick();
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (bus.key_ready === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++; if (!seen) $display("FAIL b2b_ready_timeout got=%b want=1", bus.key_ready); else passes++;
        bus.key_code = 4'd0;
    endtask

    task automatic test_capture();
        logic [4:0] exp_lev;
        capture_pulse(5'h13, 1'b1, 1'b1, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        checks++; if (bus.typed_valid !== 1'b1) $display("FAIL cap_valid got=%b want=1", bus.typed_valid); else passes++;
        checks++; if (bus.typed_code !== 5'h13) $display("FAIL cap_code got=%h want=13", bus.typed_code); else passes++;
        checks++; if (bus.typed_an !== 1'b1) $display("FAIL cap_an got=%b want=1", bus.typed_an); else passes++;
        for (int k = 0; k < 8; k++) begin
            exp_lev = (k < 5) ? 5'h13 : 5'h00;
            checks++; if (bus.lev_out !== exp_lev) $display("FAIL cap_echo cyc=%0d got=%h want=%h", k, bus.lev_out, exp_lev); else passes++;
            tick();
        end
        bus.typed_ready = 1'b1;
        got = '{an: bus.typed_an, code: bus.typed_code};
        if (exp_q.size() == 0) begin
            checks++; $display("FAIL cap_drain_empty got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            checks++; if (bus.typed_valid !== 1'b1 || got !== want) $display("FAIL cap_drain got=%h want=%h", got, want); else passes++;
        end
        mdl_full = 1'b0;
        tick();
        bus.typed_ready = 1'b0;
        checks++; if (bus.typed_valid !== 1'b0) $display("FAIL cap_valid_fall got=%b want=0", bus.typed_valid); else passes++;
    endtask

    task automatic test_drain_capture();
        capture_pulse(5'h0A, 1'b0, 1'b1, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        tick();
        bus.typed_ready = 1'b1;
        got = '{an: bus.typed_an, code: bus.typed_code};
        if (exp_q.size() == 0) begin
            checks++; $display("FAIL dc_drain_empty got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            checks++; if (got !== want) $display("FAIL dc_drain_first got=%h want=%h", got, want); else passes++;
        end
        capture_pulse(5'h07, 1'b1, 1'b1, 1'b1);
        tick();
        bus.typed_ready = 1'b0;
        bus.pl1_exc     = 1'b0;
        checks++; if (bus.typed_valid !== 1'b1) $display("FAIL dc_valid got=%b want=1", bus.typed_valid); else passes++;
        checks++; if (bus.typed_code !== 5'h07) $display("FAIL dc_code got=%h want=07", bus.typed_code); else passes++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL dc_overrun got=%b want=0", bus.overrun); else passes++;
        checks++; if (bus.lev_out !== 5'h07) $display("FAIL dc_echo got=%h want=07", bus.lev_out); else passes++;
        bus.typed_ready = 1'b1;
        got = '{an: bus.typed_an, code: bus.typed_code};
        if (exp_q.size() == 0) begin
            checks++; $display("FAIL dc_drain2_empty got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            checks++; if (got !== want) $display("FAIL dc_drain_second got=%h want=%h", got, want); else passes++;
        end
        mdl_full = 1'b0;
        tick();
        bus.typed_ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_exc_hold();
        int n_valid;
        int n_echo;
        int n_bad;
        n_valid = 0;
        n_echo  = 0;
        bus.typed_ready = 1'b1;
        capture_pulse(5'h1F, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 9) bus.pl1_exc = 1'b0;
            if (bus.lev_out === 5'h1F) n_echo++;
            if (bus.typed_valid === 1'b1) begin
                n_valid++;
                got = '{an: bus.typed_an, code: bus.typed_code};
                if (exp_q.size() == 0) begin
                    checks++; $display("FAIL hold_extra_capture got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    checks++; if (got !== want) $display("FAIL hold_data got=%h want=%h", got, want); else passes++;
                end
                mdl_full = 1'b0;
            end
        end
        checks++; if (n_valid != 1) $display("FAIL hold_capture_count got=%0d want=1", n_valid); else passes++;
        checks++; if (n_echo != 5) $display("FAIL hold_echo_cycles got=%0d want=5", n_echo); else passes++;
        n_bad = 0;
        capture_pulse(5'h0C, 1'b0, 1'b0, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.typed_valid !== 1'b0 || bus.lev_out !== 5'h0) n_bad++;
            tick();
        end
        checks++; if (n_bad != 0) $display("FAIL notype_ignored got=%0d want=0", n_bad); else passes++;
        bus.typed_ready = 1'b0;
    endtask

    task automatic test_overrun();
        capture_pulse(5'h0A, 1'b0, 1'b1, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        tick();
        capture_pulse(5'h15, 1'b1, 1'b1, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        tick();
        checks++; if (bus.typed_valid !== 1'b1) $display("FAIL ovr_valid got=%b want=1", bus.typed_valid); else passes++;
        checks++; if (bus.typed_code !== 5'h0A) $display("FAIL ovr_kept_code got=%h want=0a", bus.typed_code); else passes++;
        checks++; if (bus.overrun !== mdl_overrun) $display("FAIL ovr_flag got=%b want=%b", bus.overrun, mdl_overrun); else passes++;
        checks++; if (bus.lev_out !== 5'h15) $display("FAIL ovr_echo got=%h want=15", bus.lev_out); else passes++;
        bus.typed_ready = 1'b1;
        got = '{an: bus.typed_an, code: bus.typed_code};
        if (exp_q.size() == 0) begin
            checks++; $display("FAIL ovr_drain_empty got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            checks++; if (got !== want) $display("FAIL ovr_drain got=%h want=%h", got, want); else passes++;
        end
        mdl_full = 1'b0;
        tick();
        bus.typed_ready = 1'b0;
        checks++; if (bus.typed_valid !== 1'b0) $display("FAIL ovr_valid_fall got=%b want=0", bus.typed_valid); else passes++;
        checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got=%b want=1", bus.overrun); else passes++;
    endtask

    task automatic test_reset_mid();
        bus.key_code  = 4'd3;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        capture_pulse(5'h09, 1'b1, 1'b1, 1'b0);
        tick();
        bus.pl1_exc = 1'b0;
        tick();
        checks++; if (bus.key_lines !== 13'h0008) $display("FAIL mid_pre_lines got=%h want=0008", bus.key_lines); else passes++;
        checks++; if (bus.lev_out !== 5'h09) $display("FAIL mid_pre_echo got=%h want=09", bus.lev_out); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mdl_full    = 1'b0;
        mdl_overrun = 1'b0;
        checks++; if (bus.key_lines !== 13'h0) $display("FAIL mid_lines got=%h want=0", bus.key_lines); else passes++;
        checks++; if (bus.lev_out !== 5'h0) $display("FAIL mid_echo got=%h want=0", bus.lev_out); else passes++;
        checks++; if (bus.typed_valid !== 1'b0) $display("FAIL mid_typed_valid got=%b want=0", bus.typed_valid); else passes++;
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL mid_key_ready got=%b want=1", bus.key_ready); else passes++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL mid_overrun got=%b want=0", bus.overrun); else passes++;
        bus.key_code  = 4'd0;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        checks++; if (bus.key_lines !== 13'h0001) $display("FAIL mid_recover got=%h want=0001", bus.key_lines); else passes++;
        for (int k = 0; k < 14; k++) tick();
        checks++; if (bus.key_ready !== 1'b1) $display("FAIL mid_recover_ready got=%b want=1", bus.key_ready); else passes++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_key_a();
        test_bad_key();
        test_back_to_back();
        test_capture();
        test_drain_capture();
        test_exc_hold();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
